// File: rtl/xadc_mux_pkg.sv
// Shared types, channel ids and frame-byte helpers for the XADC stream multiplexer.
package xadc_mux_pkg;

   typedef enum logic [1:0] {IDLE, HDR, LOW} mux_state_t;
   typedef logic chan_id_t;

   localparam chan_id_t CH_VOLTAGE  = 1'b0;
   localparam chan_id_t CH_CURRENT  = 1'b1;
   localparam logic     HDR_FLAG    = 1'b1;
   localparam int       SAMPLE_BITS = 12;

   // Header carries the only MSB=1 in the stream so the host can resync on it.
   function automatic logic [7:0] hdr_byte(input chan_id_t ch, input logic [5:0] smp_hi);
      return {HDR_FLAG, ch, smp_hi};
   endfunction

   function automatic logic [7:0] low_byte(input logic [5:0] smp_lo);
      return {2'b00, smp_lo};
   endfunction

endpackage

// File: rtl/xadc_sample_decim.sv
// Per-channel decimation counter: flags the sample that will be forwarded (count 0).
module xadc_sample_decim #(
   parameter int unsigned DECIM_LOG2 = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic accept_i,
   output logic fwd_o
);

   localparam logic [DECIM_LOG2-1:0] CNT_ONE = 1;

   logic [DECIM_LOG2-1:0] cnt_q, cnt_d;

   // Natural wrap of the counter gives 2^DECIM_LOG2-1 -> 0.
   assign cnt_d = accept_i ? cnt_q + CNT_ONE : cnt_q;
   assign fwd_o = (cnt_q == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/xadc_stream_mux.sv
// Round-robin merge of the two XADC sample streams into a 2-byte framed byte stream.
// Optional per-channel decimation is built when XADC_MUX_DECIM_EN is defined.
//
// state | meaning
// IDLE  | no frame in flight, waiting for a grant
// HDR   | header byte {1, ch, smp[11:6]} presented
// LOW   | low byte {00, smp[5:0]} presented; a new grant may be taken on its handshake
module xadc_stream_mux
   import xadc_mux_pkg::*;
#(
   parameter int unsigned IN_WIDTH   = 16,
   parameter int unsigned SAMPLE_LSB = 4,
   parameter int unsigned DECIM_LOG2 = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [1:0]          ch_en,
   input  logic [IN_WIDTH-1:0] s0_tdata,
   input  logic                s0_tvalid,
   output logic                s0_tready,
   input  logic [IN_WIDTH-1:0] s1_tdata,
   input  logic                s1_tvalid,
   output logic                s1_tready,
   output logic [7:0]          m_tdata,
   output logic                m_tvalid,
   input  logic                m_tready
);

   mux_state_t             state_q, state_d;
   logic [7:0]             m_tdata_q, m_tdata_d;
   logic                   m_tvalid_q, m_tvalid_d;
   logic [5:0]             smp_lo_q, smp_lo_d;
   chan_id_t               last_ch_q, last_ch_d;

   logic [1:0]             vld, req, gnt, fwd, drop_rdy, tready;
   logic                   grant_ok;
   chan_id_t               gnt_ch;
   logic [SAMPLE_BITS-1:0] smp0, smp1, smp_sel;
   logic                   unused_tdata;

   assign vld          = {s1_tvalid, s0_tvalid};
   assign smp0         = s0_tdata[SAMPLE_LSB +: SAMPLE_BITS];
   assign smp1         = s1_tdata[SAMPLE_LSB +: SAMPLE_BITS];
   assign unused_tdata = ^{s0_tdata, s1_tdata};

`ifdef XADC_MUX_DECIM_EN
   logic [1:0] acc;

   assign acc = vld & ch_en & tready;

   xadc_sample_decim #(.DECIM_LOG2(DECIM_LOG2)) u_decim_v (
      .clk      (clk),
      .rst_n    (rst_n),
      .accept_i (acc[CH_VOLTAGE]),
      .fwd_o    (fwd[CH_VOLTAGE])
   );

   xadc_sample_decim #(.DECIM_LOG2(DECIM_LOG2)) u_decim_i (
      .clk      (clk),
      .rst_n    (rst_n),
      .accept_i (acc[CH_CURRENT]),
      .fwd_o    (fwd[CH_CURRENT])
   );

   // Samples to be dropped are swallowed whenever the other channel is not being granted.
   assign drop_rdy = ch_en & ~fwd & {~gnt[0], ~gnt[1]};
`else
   logic [31:0] unused_decim;

   assign unused_decim = 32'(DECIM_LOG2);
   assign fwd          = 2'b11;
   assign drop_rdy     = 2'b00;
`endif

   assign req      = ch_en & vld & fwd;
   assign grant_ok = (state_q == IDLE) || ((state_q == LOW) && m_tready);

   always_comb begin
      gnt = 2'b00;
      if (grant_ok) begin
         case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_ch_q == CH_CURRENT) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
         endcase
      end
   end

   assign gnt_ch  = gnt[CH_CURRENT];
   assign smp_sel = gnt[CH_CURRENT] ? smp1 : smp0;

   // Disabled channels are always drained so the upstream adapter never stalls.
   assign tready    = gnt | ~ch_en | drop_rdy;
   assign s0_tready = tready[CH_VOLTAGE];
   assign s1_tready = tready[CH_CURRENT];

   always_comb begin
      state_d    = state_q;
      m_tdata_d  = m_tdata_q;
      m_tvalid_d = m_tvalid_q;
      smp_lo_d   = smp_lo_q;
      last_ch_d  = last_ch_q;

      unique case (state_q)
         IDLE: ;
         HDR: begin
            if (m_tready) begin
               state_d   = LOW;
               m_tdata_d = low_byte(smp_lo_q);
            end
         end
         LOW: begin
            if (m_tready) begin
               state_d    = IDLE;
               m_tvalid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase

      if (|gnt) begin
         state_d    = HDR;
         m_tvalid_d = 1'b1;
         m_tdata_d  = hdr_byte(gnt_ch, smp_sel[11:6]);
         smp_lo_d   = smp_sel[5:0];
         last_ch_d  = gnt_ch;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         m_tdata_q  <= '0;
         m_tvalid_q <= 1'b0;
         smp_lo_q   <= '0;
         last_ch_q  <= CH_CURRENT;
      end else begin
         state_q    <= state_d;
         m_tdata_q  <= m_tdata_d;
         m_tvalid_q <= m_tvalid_d;
         smp_lo_q   <= smp_lo_d;
         last_ch_q  <= last_ch_d;
      end
   end

   assign m_tdata  = m_tdata_q;
   assign m_tvalid = m_tvalid_q;

endmodule
